// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared types, codes and limits for the time/alarm edit controller
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_H,
        ST_EDIT_M,
        ST_EDIT_S,
        ST_COMMIT,
        ST_WAIT_EXIT
    } state_t;

    localparam logic [1:0] MODE_RUN       = 2'b00;
    localparam logic [1:0] MODE_SET_TIME  = 2'b01;
    localparam logic [1:0] MODE_SET_ALARM = 2'b10;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [4:0] HOUR24_MAX = 5'd23;
    localparam logic [4:0] HOUR12_MAX = 5'd12;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    function automatic logic is_set_mode(input logic [1:0] m);
        return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
    endfunction

    // Maps a 24 h hour onto the 1..12 range used while editing in 12 h format.
    function automatic logic [4:0] norm_hour12(input logic [4:0] h);
        if (h == 5'd0)
            return HOUR12_MAX;
        else if (h > HOUR12_MAX)
            return h - HOUR12_MAX;
        else
            return h;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - blink phase generator with synchronous restart to the visible phase
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_blink
);

    localparam int CW = $clog2(BLINK_DIV);

    logic [CW-1:0] r_cnt;
    logic          r_blink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_blink <= 1'b1;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_blink <= 1'b1;
        end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
            r_cnt   <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_blink = r_blink;

endmodule

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - edit sequencer for time/alarm fields with valid/ack load handshake
module time_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       time_format,
    input  logic       pb_next,
    input  logic       pb_inc,
    input  logic [4:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    input  logic [4:0] alm_h,
    input  logic [5:0] alm_m,
    input  logic [5:0] alm_s,
    output logic [4:0] edit_h,
    output logic [5:0] edit_m,
    output logic [5:0] edit_s,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic       load_valid,
    output logic       load_tgt,
    input  logic       load_ack,
    output logic       busy
);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_mode_q;
    logic [4:0] r_edit_h, w_edit_h_nxt;
    logic [5:0] r_edit_m, w_edit_m_nxt;
    logic [5:0] r_edit_s, w_edit_s_nxt;
    logic       r_load_tgt, w_load_tgt_nxt;
    logic       w_blink_clr;

    logic       w_in_edit;
    logic       w_in_edit_nxt;
    logic       w_entry;
    logic [4:0] w_cap_h_raw;
    logic [4:0] w_cap_h;
    logic [4:0] w_h_inc;
    logic [5:0] w_m_inc;
    logic [5:0] w_s_inc;

    assign w_in_edit = (r_state == ST_EDIT_H) || (r_state == ST_EDIT_M) || (r_state == ST_EDIT_S);
    assign w_entry   = is_set_mode(mode) && (mode != r_mode_q) && ((r_state == ST_IDLE) || w_in_edit);

    assign w_cap_h_raw = (mode == MODE_SET_ALARM) ? alm_h : cur_h;
    assign w_cap_h     = time_format ? norm_hour12(w_cap_h_raw) : w_cap_h_raw;

    // Limits are compared before adding so the sum never needs an extra bit.
    assign w_h_inc = time_format ? ((r_edit_h >= HOUR12_MAX) ? 5'd1 : r_edit_h + 5'd1)
                                 : ((r_edit_h >= HOUR24_MAX) ? 5'd0 : r_edit_h + 5'd1);
    assign w_m_inc = (r_edit_m >= MINSEC_MAX) ? 6'd0 : r_edit_m + 6'd1;
    assign w_s_inc = (r_edit_s >= MINSEC_MAX) ? 6'd0 : r_edit_s + 6'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_edit_h_nxt   = r_edit_h;
        w_edit_m_nxt   = r_edit_m;
        w_edit_s_nxt   = r_edit_s;
        w_load_tgt_nxt = r_load_tgt;
        w_blink_clr    = 1'b0;

        if (w_entry) begin
            w_edit_h_nxt   = w_cap_h;
            w_edit_m_nxt   = (mode == MODE_SET_ALARM) ? alm_m : cur_m;
            w_edit_s_nxt   = (mode == MODE_SET_ALARM) ? alm_s : cur_s;
            w_load_tgt_nxt = mode[1];
            w_state_nxt    = ST_EDIT_H;
            w_blink_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                    if (!is_set_mode(mode)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        if (pb_inc) begin
                            w_blink_clr = 1'b1;
                            if (r_state == ST_EDIT_H)
                                w_edit_h_nxt = w_h_inc;
                            else if (r_state == ST_EDIT_M)
                                w_edit_m_nxt = w_m_inc;
                            else
                                w_edit_s_nxt = w_s_inc;
                        end
                        if (pb_next) begin
                            w_blink_clr = 1'b1;
                            if (r_state == ST_EDIT_H)
                                w_state_nxt = ST_EDIT_M;
                            else if (r_state == ST_EDIT_M)
                                w_state_nxt = ST_EDIT_S;
                            else
                                w_state_nxt = ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (load_ack)
                        w_state_nxt = ST_WAIT_EXIT;
                end
                ST_WAIT_EXIT: begin
                    if (!is_set_mode(mode))
                        w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        // Holding the timer cleared outside editing keeps the field visible.
        if (!w_in_edit_nxt)
            w_blink_clr = 1'b1;
    end

    assign w_in_edit_nxt = (w_state_nxt == ST_EDIT_H) || (w_state_nxt == ST_EDIT_M) ||
                           (w_state_nxt == ST_EDIT_S);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mode_q   <= MODE_RUN;
            r_edit_h   <= '0;
            r_edit_m   <= '0;
            r_edit_s   <= '0;
            r_load_tgt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode_q   <= mode;
            r_edit_h   <= w_edit_h_nxt;
            r_edit_m   <= w_edit_m_nxt;
            r_edit_s   <= w_edit_s_nxt;
            r_load_tgt <= w_load_tgt_nxt;
        end
    end

    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_blink_clr),
        .o_blink (blink)
    );

    always_comb begin
        field_sel = FIELD_NONE;
        case (r_state)
            ST_EDIT_H: field_sel = FIELD_HOUR;
            ST_EDIT_M: field_sel = FIELD_MIN;
            ST_EDIT_S: field_sel = FIELD_SEC;
            default:   field_sel = FIELD_NONE;
        endcase
    end

    assign edit_h     = r_edit_h;
    assign edit_m     = r_edit_m;
    assign edit_s     = r_edit_s;
    assign load_tgt   = r_load_tgt;
    assign load_valid = (r_state == ST_COMMIT);
    assign busy       = (r_state != ST_IDLE);

endmodule
